// File: rtl/lut_neuron_loader_pkg.sv
// Shared definitions for the LogicNets LUT neuron loader.
//   - FSM state encoding (IDLE/LOAD/DRAIN/COMMIT)
//   - geometry helpers: table bits, words per neuron, beats per frame
//   - index / counter width helpers (never narrower than 1 bit)
package logicnets_cfg_pkg;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_LOAD   = 2'd1;
   localparam state_t ST_DRAIN  = 2'd2;
   localparam state_t ST_COMMIT = 2'd3;

   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

   function automatic int calc_tbits(input int in_bits, input int out_bits);
      return (1 << in_bits) * out_bits;
   endfunction

   function automatic int calc_wpn(input int in_bits, input int out_bits, input int word_w);
      return (calc_tbits(in_bits, out_bits) + word_w - 1) / word_w;
   endfunction

   function automatic int calc_total(input int in_bits, input int out_bits, input int word_w,
                                     input int num_neurons);
      return num_neurons * calc_wpn(in_bits, out_bits, word_w);
   endfunction

   function automatic int cnt_w(input int total);
      return clog2_min1(total);
   endfunction

   function automatic int idx_w(input int num_neurons);
      return clog2_min1(num_neurons);
   endfunction

endpackage

// File: rtl/lut_neuron_loader_if.sv
// Config stream + lookup bus of the LUT neuron loader.
//   cfg_valid/cfg_ready/cfg_data/cfg_last : config beats (host -> loader)
//   lut_req/lut_idx/lut_in                : lookup request (layer -> loader)
//   lut_vld/lut_out                       : lookup response, 1 cycle later
// master = host/layer side, slave = loader.
interface lut_neuron_loader_if
   import logicnets_cfg_pkg::*;
#(
   parameter int IN_BITS     = 6,
   parameter int OUT_BITS    = 1,
   parameter int NUM_NEURONS = 64,
   parameter int WORD_W      = 32
) ();
   localparam int IDX_W = idx_w(NUM_NEURONS);

   logic                cfg_valid;
   logic                cfg_ready;
   logic [WORD_W-1:0]   cfg_data;
   logic                cfg_last;
   logic                lut_req;
   logic [IDX_W-1:0]    lut_idx;
   logic [IN_BITS-1:0]  lut_in;
   logic                lut_vld;
   logic [OUT_BITS-1:0] lut_out;

   modport master (output cfg_valid, cfg_data, cfg_last, lut_req, lut_idx, lut_in,
                   input  cfg_ready, lut_vld, lut_out);
   modport slave  (input  cfg_valid, cfg_data, cfg_last, lut_req, lut_idx, lut_in,
                   output cfg_ready, lut_vld, lut_out);
endinterface

// File: rtl/lut_neuron_loader_bank.sv
// One truth-table bank: NUM_NEURONS rows of WPN*WORD_W bits.
//   we_i/wr_nrn_i/wr_wrd_i/wr_data_i : word-granular write port
//   rd_nrn_i/rd_v_i -> rd_o          : combinational entry read
// Entry for input v, output bit o lives at row bit v*OUT_BITS+o; padding
// above the table bits is stored but never read.
module lut_bank
   import logicnets_cfg_pkg::*;
#(
   parameter  int IN_BITS     = 6,
   parameter  int OUT_BITS    = 1,
   parameter  int NUM_NEURONS = 64,
   parameter  int WORD_W      = 32,
   localparam int WPN         = calc_wpn(IN_BITS, OUT_BITS, WORD_W),
   localparam int IDX_W       = idx_w(NUM_NEURONS),
   localparam int WRD_W       = clog2_min1(WPN),
   localparam int ROW_W       = WPN * WORD_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we_i,
   input  logic [IDX_W-1:0]    wr_nrn_i,
   input  logic [WRD_W-1:0]    wr_wrd_i,
   input  logic [WORD_W-1:0]   wr_data_i,
   input  logic [IDX_W-1:0]    rd_nrn_i,
   input  logic [IN_BITS-1:0]  rd_v_i,
   output logic [OUT_BITS-1:0] rd_o
);
   logic [NUM_NEURONS-1:0][ROW_W-1:0] mem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_q <= '0;
      else if (we_i) mem_q[wr_nrn_i][wr_wrd_i*WORD_W +: WORD_W] <= wr_data_i;
   end

   assign rd_o = mem_q[rd_nrn_i][rd_v_i*OUT_BITS +: OUT_BITS];
endmodule

// File: rtl/lut_neuron_loader.sv
// Runtime loader for LogicNets LUT neurons with a double-buffered store.
//   clk, rst_n   : clock, async active-low reset
//   bus (slave)  : config stream in, lookup request/response
//   load_done    : pulse while committing a complete frame (bank swap)
//   load_err     : pulse the cycle after a malformed frame ends
//   active_bank  : bank served to lookups; frames fill the other one
module lut_neuron_loader
   import logicnets_cfg_pkg::*;
#(
   parameter int IN_BITS     = 6,
   parameter int OUT_BITS    = 1,
   parameter int NUM_NEURONS = 64,
   parameter int WORD_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   lut_neuron_loader_if.slave   bus,
   output logic                 load_done,
   output logic                 load_err,
   output logic                 active_bank
);
   localparam int WPN   = calc_wpn(IN_BITS, OUT_BITS, WORD_W);
   localparam int TOTAL = calc_total(IN_BITS, OUT_BITS, WORD_W, NUM_NEURONS);
   localparam int CNT_W = cnt_w(TOTAL);
   localparam int IDX_W = idx_w(NUM_NEURONS);
   localparam int WRD_W = clog2_min1(WPN);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                bank_q, bank_d;
   logic                err_q, err_d;
   logic                vld_q;
   logic [OUT_BITS-1:0] out_q;

   logic                acc, last_beat, wr_en, idx_ok;
   logic [IDX_W-1:0]    wr_nrn;
   logic [WRD_W-1:0]    wr_wrd;
   logic [1:0]          we;
   logic [1:0][OUT_BITS-1:0] rd;

   assign bus.cfg_ready = (state_q != ST_COMMIT);
   assign acc           = bus.cfg_valid & bus.cfg_ready;
   assign last_beat     = (cnt_q == CNT_W'(TOTAL - 1));
   assign wr_en         = acc & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
   assign wr_nrn        = IDX_W'(32'(cnt_q) / WPN);
   assign wr_wrd        = WRD_W'(32'(cnt_q) % WPN);

   // Out-of-range neuron indices only exist when NUM_NEURONS is not a power of 2.
   if (NUM_NEURONS == (1 << IDX_W)) begin : g_idx_full
      assign idx_ok = 1'b1;
   end else begin : g_idx_part
      assign idx_ok = (32'(bus.lut_idx) < NUM_NEURONS);
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign we[b] = wr_en & (bank_q != 1'(b));
      lut_bank #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS),
                 .NUM_NEURONS(NUM_NEURONS), .WORD_W(WORD_W)) u_bank (
         .clk      (clk),
         .rst_n    (rst_n),
         .we_i     (we[b]),
         .wr_nrn_i (wr_nrn),
         .wr_wrd_i (wr_wrd),
         .wr_data_i(bus.cfg_data),
         .rd_nrn_i (bus.lut_idx),
         .rd_v_i   (bus.lut_in),
         .rd_o     (rd[b])
      );
   end

   // IDLE and LOAD share one beat rule: IDLE is simply LOAD with cnt_q==0.
   // The counter holds at TOTAL-1 through DRAIN/COMMIT so it never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bank_d  = bank_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE, ST_LOAD: begin
            if (acc) begin
               if (last_beat) begin
                  state_d = bus.cfg_last ? ST_COMMIT : ST_DRAIN;
               end else if (bus.cfg_last) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_LOAD;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (acc && bus.cfg_last) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         ST_COMMIT: begin
            bank_d  = ~bank_q;
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bank_q  <= 1'b0;
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
         err_q   <= err_d;
         vld_q   <= bus.lut_req;
         // Read before the swap edge, so a COMMIT-cycle request sees the old bank.
         if (bus.lut_req) out_q <= idx_ok ? rd[bank_q] : '0;
      end
   end

   assign bus.lut_vld = vld_q;
   assign bus.lut_out = out_q;
   assign load_done   = (state_q == ST_COMMIT);
   assign load_err    = err_q;
   assign active_bank = bank_q;
endmodule

// File: tb/tb_lut_neuron_loader.sv
module tb_lut_neuron_loader;
   localparam int IN_BITS     = 6;
   localparam int OUT_BITS    = 1;
   localparam int NUM_NEURONS = 64;
   localparam int WORD_W      = 32;
   localparam int TBITS       = (1 << IN_BITS) * OUT_BITS;
   localparam int WPN         = (TBITS + WORD_W - 1) / WORD_W;
   localparam int TOTAL       = NUM_NEURONS * WPN;
   localparam int IDX_W       = $clog2(NUM_NEURONS);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic load_done, load_err, active_bank;

   lut_neuron_loader_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS),
                          .NUM_NEURONS(NUM_NEURONS), .WORD_W(WORD_W)) bus ();

   lut_neuron_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS),
                       .NUM_NEURONS(NUM_NEURONS), .WORD_W(WORD_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .load_done  (load_done),
      .load_err   (load_err),
      .active_bank(active_bank)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_done = 0, n_err = 0, n_nrdy = 0;

   // Pulse / stall-cycle counters sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         n_done += int'(load_done);
         n_err  += int'(load_err);
         n_nrdy += int'(!bus.cfg_ready);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: two banks of whole truth tables plus the served-bank bit.
   logic [TBITS-1:0]  m_tab [2][NUM_NEURONS];
   bit                m_act;
   logic [WORD_W-1:0] fw [TOTAL+8];

   function automatic logic [OUT_BITS-1:0] m_look(input int idx, input int v);
      if (idx >= NUM_NEURONS) return '0;
      return m_tab[m_act][idx][v*OUT_BITS +: OUT_BITS];
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int n = 0; n < NUM_NEURONS; n++) m_tab[b][n] = '0;
      m_act = 1'b0;
   endtask

   // A frame is the beats up to and including the first cfg_last; it is
   // good only if that is exactly TOTAL beats long.
   task automatic model_frame(input int last_at, output bit good);
      logic [WPN*WORD_W-1:0] row;
      good = (last_at + 1 == TOTAL);
      if (good) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            for (int w = 0; w < WPN; w++) row[w*WORD_W +: WORD_W] = fw[n*WPN + w];
            m_tab[!m_act][n] = row[TBITS-1:0];
         end
         m_act = !m_act;
      end
   endtask

   task automatic fill(input bit rnd);
      for (int i = 0; i < TOTAL + 8; i++) fw[i] = rnd ? WORD_W'($urandom) : '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [WORD_W-1:0] d, input bit last);
      int t = 0;
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = d;
      bus.cfg_last  = last;
      while (!bus.cfg_ready && t < 20) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 20) chk("rdy_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      bus.cfg_last  = 1'b0;
   endtask

   task automatic frame_chk(input string tag, input int nb, input int last_at);
      int d0, e0, r0;
      bit good;
      d0 = n_done; e0 = n_err; r0 = n_nrdy;
      for (int i = 0; i < nb; i++) beat(fw[i], i == last_at);
      idle(3);
      model_frame(last_at, good);
      chk({tag, "_done"}, 64'(n_done - d0), 64'(good));
      chk({tag, "_err"},  64'(n_err - e0),  64'(!good));
      chk({tag, "_nrdy"}, 64'(n_nrdy - r0), 64'(good));
      chk({tag, "_bank"}, 64'(active_bank), 64'(m_act));
   endtask

   task automatic look_exp(input int idx, input int v, input logic [OUT_BITS-1:0] exp);
      bus.lut_req = 1'b1;
      bus.lut_idx = IDX_W'(idx);
      bus.lut_in  = IN_BITS'(v);
      @(posedge clk); #1;
      bus.lut_req = 1'b0;
      chk("lk_vld", 64'(bus.lut_vld), 64'd1);
      chk($sformatf("lk_out[%0d][%0d]", idx, v), 64'(bus.lut_out), 64'(exp));
   endtask

   task automatic rand_looks(input int n);
      int idx, v;
      for (int k = 0; k < n; k++) begin
         idx = $urandom_range(0, NUM_NEURONS - 1);
         v   = $urandom_range(0, (1 << IN_BITS) - 1);
         look_exp(idx, v, m_look(idx, v));
      end
   endtask

   int          vv [5] = '{0, 1, 2, 63, 32};
   int          ee [5] = '{1, 0, 1, 1, 0};
   logic [OUT_BITS-1:0] old_o, new_o, held;
   int          r0, d0, bp;
   bit          good;

   initial begin
      #200000;
      $display("FAIL watchdog time limit");
      $fatal(1);
   end

   initial begin
      bus.cfg_valid = 1'b0; bus.cfg_data = '0; bus.cfg_last = 1'b0;
      bus.lut_req = 1'b0;   bus.lut_idx = '0;  bus.lut_in = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      chk("rst_ready", 64'(bus.cfg_ready), 64'd1);
      chk("rst_vld",   64'(bus.lut_vld),   64'd0);
      chk("rst_out",   64'(bus.lut_out),   64'd0);
      chk("rst_done",  64'(load_done),     64'd0);
      chk("rst_err",   64'(load_err),      64'd0);
      chk("rst_bank",  64'(active_bank),   64'd0);
      look_exp(5, 6'h2A, '0);
      idle(1);
      chk("hold_vld", 64'(bus.lut_vld), 64'd0);

      // Directed good frame
      fill(1'b0);
      fw[0] = 32'h0000_00F5;
      fw[1] = 32'h8000_0000;
      frame_chk("good", TOTAL, TOTAL - 1);
      for (int k = 0; k < 5; k++) look_exp(0, vv[k], OUT_BITS'(ee[k]));
      held = bus.lut_out;
      idle(2);
      chk("hold_out", 64'(bus.lut_out), 64'(held));

      // Random good frame
      fill(1'b1);
      frame_chk("rgood", TOTAL, TOTAL - 1);
      rand_looks(16);

      // Early last, single-beat frame, missing last
      fill(1'b1);
      frame_chk("early", 41, 40);
      rand_looks(6);
      frame_chk("one", 1, 0);
      fill(1'b1);
      frame_chk("drain", TOTAL + 2, TOTAL + 1);
      rand_looks(6);

      // Lookup in the COMMIT cycle sees old data, next cycle sees new data
      fill(1'b1);
      old_o = m_look(3, 5);
      bp = 5 * OUT_BITS;
      fw[3*WPN + bp/WORD_W][bp%WORD_W] = ~old_o[0];
      d0 = n_done; r0 = n_nrdy;
      for (int i = 0; i < TOTAL - 1; i++) beat(fw[i], 1'b0);
      beat(fw[TOTAL-1], 1'b1);
      chk("commit_rdy", 64'(bus.cfg_ready), 64'd0);
      look_exp(3, 5, old_o);
      model_frame(TOTAL - 1, good);
      new_o = m_look(3, 5);
      look_exp(3, 5, new_o);
      idle(2);
      chk("commit_nrdy", 64'(n_nrdy - r0), 64'd1);
      chk("commit_done", 64'(n_done - d0), 64'd1);
      chk("commit_bank", 64'(active_bank), 64'(m_act));

      // Reset in the middle of a frame
      fill(1'b1);
      for (int i = 0; i < 60; i++) beat(fw[i], 1'b0);
      rst_n = 1'b0;
      #3;
      chk("mrst_ready", 64'(bus.cfg_ready), 64'd1);
      chk("mrst_vld",   64'(bus.lut_vld),   64'd0);
      chk("mrst_out",   64'(bus.lut_out),   64'd0);
      chk("mrst_done",  64'(load_done),     64'd0);
      chk("mrst_err",   64'(load_err),      64'd0);
      chk("mrst_bank",  64'(active_bank),   64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      rand_looks(6);
      fill(1'b1);
      frame_chk("post_rst", TOTAL, TOTAL - 1);
      rand_looks(10);
      fill(1'b1);
      frame_chk("b2b", TOTAL, TOTAL - 1);
      rand_looks(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
